// File: rtl/fft_r2_stage_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_r2_stage_feeder_if
// Brief    : Sample-in / operand-pair-out handshake bundle of the radix-2 feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_r2_stage_feeder_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [31:0] out_w;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_a, out_b, out_w, out_valid, frame_done
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_a, out_b, out_w, out_valid, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/fft_r2_stage_feeder.sv
`default_nettype none
// ============================================================================
// Module   : fft_r2_stage_feeder
// Brief    : Buffers an N-sample frame, then streams DIF pairs (x[k], x[k+N/2])
//            with twiddle W_N^k into a radix-2 butterfly.
// Revision : 1.0 - initial release
// ============================================================================
module fft_r2_stage_feeder #(
  parameter int N  = 16,
  parameter int AW = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fft_r2_stage_feeder_if.slave   bus
);

  localparam int     c_half  = N / 2;
  localparam longint c_scale = 64'sd1073741824;   // 2^30 fixed-point unit
  localparam longint c_pi_fx = 64'sd3373259426;   // pi * 2^30

  localparam logic [AW-1:0] c_last_wr = AW'(N - 1);
  localparam logic [AW-2:0] c_last_rd = (AW-1)'(c_half - 1);

  // Round a 2^30-scaled value to Q1.15, half away from zero; only +1.0 saturates.
  function automatic int q15(input longint v);
    longint m;
    int     r;
    m = (v < 0) ? -v : v;
    m = (m + 64'sd16384) >>> 15;
    r = (v < 0) ? -int'(m) : int'(m);
    if (r > 32767) r = 32767;
    return r;
  endfunction

  // W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), Taylor series over [0, pi/2]
  // with the second quadrant folded back by cos(pi - t) = -cos(t).
  function automatic logic [31:0] tw_calc(input int k);
    int     kk;
    logic   neg_cos;
    longint x;
    longint term;
    longint cs;
    longint sn;
    int     re;
    int     im;
    neg_cos = (4 * k > N);
    kk      = neg_cos ? (c_half - k) : k;
    x       = (2 * c_pi_fx * longint'(kk)) / longint'(N);
    term    = c_scale;
    cs      = c_scale;
    sn      = 0;
    for (int n = 1; n <= 24; n++) begin
      term = ((term * x) / c_scale) / longint'(n);
      case (n % 4)
        1:       sn = sn + term;
        2:       cs = cs - term;
        3:       sn = sn - term;
        default: cs = cs + term;
      endcase
    end
    re = q15(neg_cos ? -cs : cs);
    im = q15(-sn);
    return {re[15:0], im[15:0]};
  endfunction

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_wr_cnt;
  logic [AW-2:0] r_rd_cnt;
  logic [31:0]   r_mem [N];
  logic [31:0]   r_out_a;
  logic [31:0]   r_out_b;
  logic [31:0]   r_out_w;
  logic          r_out_valid;
  logic          r_frame_done;

  logic [31:0]   w_rom [c_half];
  logic          w_in_ready;
  logic          w_in_fire;
  logic          w_out_fire;
  logic [AW-2:0] w_rd_nxt;
  logic [AW-2:0] w_rd_sel;

  for (genvar gk = 0; gk < c_half; gk++) begin : g_rom
    localparam logic [31:0] c_tw = tw_calc(gk);
    assign w_rom[gk] = c_tw;
  end

  assign w_in_ready = (r_state == ST_FILL);
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;
  assign w_rd_nxt   = r_rd_cnt + 1'b1;
  // Pair 0 is loaded on the final fill edge; later pairs on each accept.
  assign w_rd_sel   = (r_state == ST_FILL) ? '0 : w_rd_nxt;

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_mem[r_wr_cnt] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_FILL;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_out_a      <= '0;
      r_out_b      <= '0;
      r_out_w      <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (w_in_fire) begin
            if (r_wr_cnt == c_last_wr) begin
              r_wr_cnt    <= '0;
              r_rd_cnt    <= '0;
              r_state     <= ST_DRAIN;
              r_out_a     <= r_mem[{1'b0, w_rd_sel}];
              r_out_b     <= r_mem[{1'b1, w_rd_sel}];
              r_out_w     <= w_rom[w_rd_sel];
              r_out_valid <= 1'b1;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_out_fire) begin
            if (r_rd_cnt == c_last_rd) begin
              r_rd_cnt     <= '0;
              r_state      <= ST_FILL;
              r_out_valid  <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_rd_cnt <= w_rd_nxt;
              r_out_a  <= r_mem[{1'b0, w_rd_sel}];
              r_out_b  <= r_mem[{1'b1, w_rd_sel}];
              r_out_w  <= w_rom[w_rd_sel];
            end
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_a      = r_out_a;
  assign bus.out_b      = r_out_b;
  assign bus.out_w      = r_out_w;
  assign bus.out_valid  = r_out_valid;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
